// File: rtl/chip_valve_sequencer.sv
// Pneumatic control-layer driver for the ChIP chip: applies static valve images,
// runs peristaltic pump strokes and timed waits from a valid/ready command stream.
module chip_valve_sequencer #(
  parameter int SIZE         = 6,
  parameter int PHASE_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [18:0]      cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_dir,
  input  logic             abort,
  output logic [18:0]      valves,
  output logic [2:0]       pump,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int HC_W = $clog2(PHASE_CYCLES) + 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(PHASE_CYCLES - 1);

  localparam logic [1:0] OP_SET  = 2'd0;
  localparam logic [1:0] OP_PUMP = 2'd1;
  localparam logic [1:0] OP_WAIT = 2'd2;

  if (PHASE_CYCLES < 1 || SIZE < 1) begin : g_bad_param
    $error("chip_valve_sequencer: PHASE_CYCLES and SIZE must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUMP = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [HC_W-1:0]  hold_cnt;
  logic [2:0]       phase;
  logic [2:0]       phase_next;
  logic             phase_last;
  logic [CNT_W-1:0] remain;
  logic             pump_dir;

  // Peristaltic pattern P0..P5; a 1 closes the pad.
  function automatic logic [2:0] phase_pat(input logic [2:0] idx);
    case (idx)
      3'd0:    phase_pat = 3'b101;
      3'd1:    phase_pat = 3'b100;
      3'd2:    phase_pat = 3'b110;
      3'd3:    phase_pat = 3'b010;
      3'd4:    phase_pat = 3'b011;
      3'd5:    phase_pat = 3'b001;
      default: phase_pat = 3'b111;
    endcase
  endfunction

  // Handshake: a command transfers on a rising edge with cmd_valid && cmd_ready;
  // fields are sampled only on that edge, and abort blocks acceptance.
  assign cmd_ready = (state == S_IDLE) && !abort;

  always_comb begin
    phase_last = 1'b0;
    phase_next = phase;
    if (pump_dir) begin
      phase_last = (phase == 3'd0);
      phase_next = (phase == 3'd0) ? 3'd5 : phase - 3'd1;
    end else begin
      phase_last = (phase == 3'd5);
      phase_next = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      valves   <= '1;
      pump     <= 3'b111;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      hold_cnt <= '0;
      phase    <= 3'd0;
      remain   <= '0;
      pump_dir <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        valves <= '1;
        pump   <= 3'b111;
        busy   <= 1'b0;
        state  <= S_IDLE;
        done   <= (state != S_IDLE);
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_valid) begin
              case (cmd_op)
                OP_SET: begin
                  valves <= cmd_data;
                  done   <= 1'b1;
                end
                OP_PUMP: begin
                  if (cmd_count == '0) begin
                    done <= 1'b1;
                  end else begin
                    state    <= S_PUMP;
                    busy     <= 1'b1;
                    remain   <= cmd_count;
                    pump_dir <= cmd_dir;
                    hold_cnt <= '0;
                    phase    <= cmd_dir ? 3'd5 : 3'd0;
                    pump     <= phase_pat(cmd_dir ? 3'd5 : 3'd0);
                  end
                end
                OP_WAIT: begin
                  if (cmd_count == '0) begin
                    done <= 1'b1;
                  end else begin
                    state  <= S_WAIT;
                    busy   <= 1'b1;
                    remain <= cmd_count;
                  end
                end
                default: begin
                  done <= 1'b1;
                  err  <= 1'b1;
                end
              endcase
            end
          end
          S_PUMP: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              // remain counts strokes still to play, so it stops at 1, never wrapping.
              if (phase_last && remain == CNT_W'(1)) begin
                pump  <= 3'b111;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
              end else begin
                if (phase_last) remain <= remain - CNT_W'(1);
                phase <= phase_next;
                pump  <= phase_pat(phase_next);
              end
            end else begin
              hold_cnt <= hold_cnt + HC_W'(1);
            end
          end
          S_WAIT: begin
            if (remain == CNT_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              remain <= remain - CNT_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chip_valve_sequencer.sv
// Bench for chip_valve_sequencer: a timeline model predicts every output each cycle,
// and directed sequences pin key values with literal expectations.
module tb_chip_valve_sequencer;

  localparam int PC    = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [18:0]      cmd_data = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             cmd_dir = 1'b0;
  logic             abort = 1'b0;
  logic [18:0]      valves;
  logic [2:0]       pump;
  logic             busy;
  logic             done;
  logic             err;

  int vectors = 0;
  int miscompares = 0;

  logic [18:0] exp_q[$];

  chip_valve_sequencer #(.SIZE(6), .PHASE_CYCLES(PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_dir(cmd_dir),
    .abort(abort), .valves(valves), .pump(pump), .busy(busy), .done(done), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a running command is described by its accept edge and length,
  // and outputs are derived from the elapsed edge count.
  logic [2:0]  pat [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  logic        m_init = 1'b0;
  logic        m_active = 1'b0;
  logic        m_is_pump = 1'b0;
  logic        m_dir = 1'b0;
  longint      m_a = 0;
  longint      m_t_len = 0;
  longint      cyc = 0;
  logic [18:0] m_valves = '1;
  logic [2:0]  m_pump = 3'b111;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;

  function automatic logic [2:0] pat_at(input longint t, input logic dir);
    int k;
    k = int'((t / PC) % 6);
    return dir ? pat[5 - k] : pat[k];
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!rst_n) begin
      m_init = 1'b1; m_active = 1'b0; m_valves = '1; m_pump = 3'b111; m_busy = 1'b0;
    end else if (abort) begin
      if (m_active) m_done = 1'b1;
      m_active = 1'b0; m_valves = '1; m_pump = 3'b111; m_busy = 1'b0;
    end else if (m_active) begin
      if (cyc - m_a == m_t_len) begin
        m_active = 1'b0; m_busy = 1'b0; m_done = 1'b1;
        if (m_is_pump) m_pump = 3'b111;
      end else if (m_is_pump) begin
        m_pump = pat_at(cyc - m_a, m_dir);
      end
    end else if (cmd_valid) begin
      case (cmd_op)
        2'd0: begin m_valves = cmd_data; m_done = 1'b1; end
        2'd3: begin m_done = 1'b1; m_err = 1'b1; end
        default: begin
          if (cmd_count == 0) begin
            m_done = 1'b1;
          end else begin
            m_active = 1'b1; m_busy = 1'b1; m_a = cyc; m_dir = cmd_dir;
            m_is_pump = (cmd_op == 2'd1);
            m_t_len = m_is_pump ? longint'(cmd_count) * 6 * PC : longint'(cmd_count);
            if (m_is_pump) m_pump = pat_at(0, cmd_dir);
          end
        end
      endcase
    end
  end

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      check("valves", valves, m_valves);
      check("pump", 19'(pump), 19'(m_pump));
      check("busy", 19'(busy), 19'(m_busy));
      check("done", 19'(done), 19'(m_done));
      check("err", 19'(err), 19'(m_err));
      check("cmd_ready", 19'(cmd_ready), 19'(!m_active && !abort));
    end
  end

  // driver tasks
  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [18:0] data,
                           input logic [CNT_W-1:0] count, input logic dir);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = count; cmd_dir = dir;
  endtask

  task automatic issue(input logic [1:0] op, input logic [18:0] data,
                       input logic [CNT_W-1:0] count, input logic dir);
    drive_cmd(op, data, count, dir);
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic play_queue(input string name);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check(name, 19'(pump), exp_q.pop_front());
    end
  endtask

  initial begin
    int n;
    logic [2:0] fwd [6];
    fwd = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valves", valves, 19'h7FFFF);
    check("rst_pump", 19'(pump), 19'h7);
    check("rst_ready", 19'(cmd_ready), 19'h1);
    check("rst_done", 19'(done), 19'h0);

    // SET, then a back-to-back SET held valid through the completion cycle
    sync();
    issue(2'd0, 19'h00015, '0, 1'b0);
    drive_cmd(2'd0, 19'h40000, '0, 1'b0);
    @(negedge clk);
    check("set1_valves", valves, 19'h00015);
    check("set1_done", 19'(done), 19'h1);
    @(posedge clk);
    #2 cmd_valid = 1'b0;
    @(negedge clk);
    check("set2_valves", valves, 19'h40000);
    check("set2_done", 19'(done), 19'h1);

    // forward PUMP, two strokes
    sync();
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 6; p++)
        for (int h = 0; h < PC; h++) exp_q.push_back(19'(fwd[p]));
    issue(2'd1, 19'h0, 16'd2, 1'b0);
    play_queue("fwd_phase");
    @(negedge clk);
    check("fwd_end_pump", 19'(pump), 19'h7);
    check("fwd_end_done", 19'(done), 19'h1);
    check("fwd_valves", valves, 19'h40000);

    // reverse PUMP, one stroke
    sync();
    for (int p = 5; p >= 0; p--)
      for (int h = 0; h < PC; h++) exp_q.push_back(19'(fwd[p]));
    issue(2'd1, 19'h0, 16'd1, 1'b1);
    play_queue("rev_phase");
    @(negedge clk);
    check("rev_end_pump", 19'(pump), 19'h7);
    check("rev_end_done", 19'(done), 19'h1);

    // zero-count PUMP
    sync();
    issue(2'd1, 19'h0, 16'd0, 1'b0);
    @(negedge clk);
    check("pump0_done", 19'(done), 19'h1);
    check("pump0_pump", 19'(pump), 19'h7);
    check("pump0_busy", 19'(busy), 19'h0);

    // abort on cycle 10 of a five-stroke PUMP with a SET offered alongside
    sync();
    issue(2'd1, 19'h0, 16'd5, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    abort = 1'b1;
    drive_cmd(2'd0, 19'h00000, '0, 1'b0);
    @(negedge clk);
    check("abort_ready", 19'(cmd_ready), 19'h0);
    @(posedge clk);
    #2;
    abort = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_pump", 19'(pump), 19'h7);
    check("abort_valves", valves, 19'h7FFFF);
    check("abort_done", 19'(done), 19'h1);
    @(negedge clk);
    check("abort_no_accept", valves, 19'h7FFFF);

    // abort while idle: no done pulse
    sync();
    abort = 1'b1;
    sync();
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_done", 19'(done), 19'h0);

    // WAIT 7 with a known valve image
    sync();
    issue(2'd0, 19'h12345, '0, 1'b0);
    issue(2'd2, 19'h0, 16'd7, 1'b0);
    repeat (7) @(negedge clk);
    @(negedge clk);
    check("wait7_done", 19'(done), 19'h1);
    check("wait7_valves", valves, 19'h12345);

    // reserved opcode
    sync();
    issue(2'd3, 19'h0, 16'd0, 1'b0);
    @(negedge clk);
    check("rsv_done", 19'(done), 19'h1);
    check("rsv_err", 19'(err), 19'h1);
    check("rsv_valves", valves, 19'h12345);

    // reset in the middle of a WAIT
    sync();
    issue(2'd2, 19'h0, 16'd20, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_done", 19'(done), 19'h0);
    check("midrst_busy", 19'(busy), 19'h0);
    check("midrst_valves", valves, 19'h7FFFF);

    // maximum WAIT must run to completion
    sync();
    issue(2'd2, 19'h0, 16'hFFFF, 1'b0);
    n = 0;
    @(negedge clk);
    while (!done && n < 70000) begin
      n++;
      @(negedge clk);
    end
    check("waitmax_len", 19'(n), 19'd65535);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
